// File: rtl/bbl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bbl_pkg                                                                  |
// | Shared state encoding and sizing helpers for breadboard_lut_seq.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bbl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bbl_state_t;

    function automatic int bbl_depth(input int n_in);
        return 1 << n_in;
    endfunction

    // One extra bit so the sweep counter reaches DEPTH without wrapping.
    function automatic int bbl_cnt_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbl_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bbl_table                                                                |
// | DEPTH x N_OUT truth-table store, cleared on reset, 1 write / 1 read port.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bbl_table #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [N_IN-1:0]  i_waddr,
    input  logic [N_OUT-1:0] i_wdata,
    input  logic [N_IN-1:0]  i_raddr,
    output logic [N_OUT-1:0] o_rdata
);
    import bbl_pkg::*;

    localparam int c_DEPTH = bbl_depth(N_IN);

    logic [N_OUT-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read sees the pre-edge word, giving read-before-write.
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/breadboard_lut_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | breadboard_lut_seq                                                       |
// | Loadable registered truth table with valid/ready eval and full sweep.    |
// | Optional macro BBL_PARITY_EN adds the out_par result bit.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module breadboard_lut_seq #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_vec,
    output logic [N_IN-1:0]  out_idx,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done
`ifdef BBL_PARITY_EN
    ,
    output logic             out_par
`endif
);
    import bbl_pkg::*;

    localparam int                 c_CNT_W   = bbl_cnt_w(N_IN);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

    bbl_state_t         r_state;
    bbl_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_out_valid;
    logic [N_OUT-1:0]   r_out_vec;
    logic [N_IN-1:0]    r_out_idx;
    logic               r_cfg_err;
    logic               r_sweep_done;

    logic               w_load_ok;
    logic               w_load;
    logic               w_wr_ok;
    logic               w_in_ready;
    logic               w_done_nxt;
    logic [N_IN-1:0]    w_rd_addr;
    logic [N_OUT-1:0]   w_rd_data;

    assign w_load_ok = ~r_out_valid | out_ready;
    assign w_wr_ok   = cfg_we & (r_state == IDLE) & ~r_out_valid;

    bbl_table #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_ok),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_rd_addr   = in_vec;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = w_load_ok;
                w_load     = in_valid & w_load_ok;
                if (sweep_start & ~r_out_valid & ~in_valid) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                w_rd_addr = r_cnt[N_IN-1:0];
                if (w_load_ok & ~r_cnt[N_IN]) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
                // Counter at DEPTH means the slot can only hold the final index.
                if (r_cnt[N_IN] & r_out_valid & out_ready) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_vec    <= '0;
            r_out_idx    <= '0;
            r_cfg_err    <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_cfg_err    <= cfg_we & ~w_wr_ok;
            r_sweep_done <= w_done_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_vec   <= w_rd_data;
                r_out_idx   <= w_rd_addr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef BBL_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= ^w_rd_data;
        end
    end

    assign out_par = r_out_par;
`endif

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_vec    = r_out_vec;
    assign out_idx    = r_out_idx;
    assign cfg_err    = r_cfg_err;
    assign sweep_busy = (r_state == SWEEP);
    assign sweep_done = r_sweep_done;

endmodule
`default_nettype wire

// File: tb/tb_breadboard_lut_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_breadboard_lut_seq                                                    |
// | Self-checking bench for breadboard_lut_seq against a table/slot model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_breadboard_lut_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [N_IN-1:0]  cfg_addr = '0;
    logic [N_OUT-1:0] cfg_data = '0;
    logic             cfg_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N_OUT-1:0] out_vec;
    logic [N_IN-1:0]  out_idx;
    logic             sweep_start = 1'b0;
    logic             sweep_busy;
    logic             sweep_done;
`ifdef BBL_PARITY_EN
    logic             out_par;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [N_OUT-1:0] m_tbl [DEPTH];

    always #5 clk = ~clk;

    breadboard_lut_seq #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .out_idx     (out_idx),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
`ifdef BBL_PARITY_EN
        ,
        .out_par     (out_par)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick;
        cfg_we = 1'b0;
        m_tbl[a] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        tick; tick;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_vec !== '0) $display("FAIL reset_out_vec: got %h want 000", out_vec); else n_pass++;
        n_total++; if (out_idx !== '0) $display("FAIL reset_out_idx: got %h want 0", out_idx); else n_pass++;
        n_total++; if ({cfg_err, sweep_busy, sweep_done} !== 3'b000)
            $display("FAIL reset_flags: got err/busy/done %b want 000", {cfg_err, sweep_busy, sweep_done}); else n_pass++;
`ifdef BBL_PARITY_EN
        n_total++; if (out_par !== 1'b0) $display("FAIL reset_par: got %b want 0", out_par); else n_pass++;
`endif
        rst = 1'b0;
        tick;
    endtask

    task automatic test_first_eval;
        in_vec = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL first_in_ready: got %b want 1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_vec !== 10'h000) $display("FAIL first_vec: got %h want 000", out_vec); else n_pass++;
        n_total++; if (out_idx !== 4'h5) $display("FAIL first_idx: got %h want 5", out_idx); else n_pass++;
        tick;
        n_total++; if (out_valid !== 1'b0) $display("FAIL first_drain: got valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_write_eval;
        write_word(4'h3, 10'h2A5);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL write_err: got %b want 0", cfg_err); else n_pass++;
        in_vec = 4'h3; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n_total++; if (out_vec !== 10'h2A5 || out_idx !== 4'h3)
            $display("FAIL write_eval: got %h@%h want 2a5@3", out_vec, out_idx); else n_pass++;
        tick;
    endtask

    task automatic test_read_before_write;
        logic [N_OUT-1:0] exp_old;
        exp_old = m_tbl[7];
        cfg_we = 1'b1; cfg_addr = 4'h7; cfg_data = 10'h155;
        in_valid = 1'b1; in_vec = 4'h7;
        tick;
        cfg_we = 1'b0;
        m_tbl[7] = 10'h155;
        n_total++; if (out_vec !== exp_old) $display("FAIL rbw_old: got %h want %h", out_vec, exp_old); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL rbw_err: got %b want 0", cfg_err); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_total++; if (out_vec !== 10'h155) $display("FAIL rbw_new: got %h want 155", out_vec); else n_pass++;
        tick;
    endtask

    task automatic test_start_blocked;
        sweep_start = 1'b1; in_valid = 1'b1; in_vec = 4'h3; out_ready = 1'b1;
        tick;
        sweep_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_total++; if (sweep_busy !== 1'b0) $display("FAIL blocked_busy: got %b want 0", sweep_busy); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_idx !== 4'h3 || out_vec !== m_tbl[3])
            $display("FAIL blocked_eval: got v%b %h@%h want v1 %h@3", out_valid, out_vec, out_idx, m_tbl[3]); else n_pass++;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
        cfg_we = 1'b1; cfg_addr = 4'h4; cfg_data = 10'h3FF;
        tick;
        cfg_we = 1'b0;
        n_total++; if (cfg_err !== 1'b1) $display("FAIL busy_write_err: got %b want 1", cfg_err); else n_pass++;
        tick;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL err_pulse_len: got %b want 0", cfg_err); else n_pass++;
        out_ready = 1'b1;
        tick;
    endtask

    task automatic test_random_eval;
        logic             m_valid;
        logic [N_IN-1:0]  m_idx;
        logic [N_OUT-1:0] m_vec;
        logic             exp_ready, exp_err, wr_ok;
        m_valid = 1'b0; m_idx = '0; m_vec = '0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 4'($urandom);
            cfg_data  = 10'($urandom);
            #1;
            exp_ready = !m_valid || out_ready;
            n_total++; if (in_ready !== exp_ready) $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ready); else n_pass++;
            exp_err = cfg_we && m_valid;
            wr_ok   = cfg_we && !m_valid;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (in_valid && exp_ready) begin
                m_valid = 1'b1; m_idx = in_vec; m_vec = m_tbl[in_vec];
            end
            if (wr_ok) m_tbl[cfg_addr] = cfg_data;
            tick;
            n_total++; if (out_valid !== m_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_total++; if (out_idx !== m_idx || out_vec !== m_vec)
                    $display("FAIL rnd_data c%0d: got %h@%h want %h@%h", c, out_vec, out_idx, m_vec, m_idx); else n_pass++;
`ifdef BBL_PARITY_EN
                n_total++; if (out_par !== ^m_vec) $display("FAIL rnd_par c%0d: got %b want %b", c, out_par, ^m_vec); else n_pass++;
`endif
            end
            n_total++; if (cfg_err !== exp_err) $display("FAIL rnd_cfg_err c%0d: got %b want %b", c, cfg_err, exp_err); else n_pass++;
        end
        cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick; tick;
    endtask

    task automatic test_sweep;
        int exp_idx, done_cnt, first_c, last_c;
        for (int i = 0; i < DEPTH; i++) write_word(4'(i), 10'(i * 3));
        out_ready = 1'b1; sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        n_total++; if (sweep_busy !== 1'b1) $display("FAIL sweep_busy_start: got %b want 1", sweep_busy); else n_pass++;
        exp_idx = 0; done_cnt = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_ready) begin
                n_total++; if (out_idx !== 4'(exp_idx) || out_vec !== m_tbl[exp_idx % DEPTH])
                    $display("FAIL sweep_item: got %h@%h want %h@%h", out_vec, out_idx, m_tbl[exp_idx % DEPTH], 4'(exp_idx)); else n_pass++;
                if (exp_idx == 0) first_c = c;
                if (exp_idx == DEPTH - 1) last_c = c;
                exp_idx++;
            end
            tick;
            if (sweep_done) begin
                done_cnt++;
                n_total++; if (last_c !== c) $display("FAIL sweep_done_time: got cycle %0d want %0d", c, last_c); else n_pass++;
                n_total++; if (sweep_busy !== 1'b0) $display("FAIL sweep_busy_end: got %b want 0", sweep_busy); else n_pass++;
            end
        end
        n_total++; if (exp_idx !== DEPTH) $display("FAIL sweep_count: got %0d want %0d", exp_idx, DEPTH); else n_pass++;
        n_total++; if (last_c - first_c !== DEPTH - 1) $display("FAIL sweep_rate: got span %0d want %0d", last_c - first_c, DEPTH - 1); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL sweep_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_sweep_backpressure;
        int               exp_idx, done_cnt;
        logic             held;
        logic [N_IN-1:0]  h_idx;
        logic [N_OUT-1:0] h_vec;
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        exp_idx = 0; done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            out_ready   = (c % 3 == 0);
            sweep_start = (c >= 5 && c < 8);
            cfg_we      = (c == 10); cfg_addr = 4'hF; cfg_data = 10'h3FF;
            #1;
            if (sweep_busy) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); else n_pass++;
            end
            held = out_valid && !out_ready;
            h_idx = out_idx; h_vec = out_vec;
            if (out_valid && out_ready) begin
                n_total++; if (out_idx !== 4'(exp_idx) || out_vec !== m_tbl[exp_idx % DEPTH])
                    $display("FAIL bp_item: got %h@%h want %h@%h", out_vec, out_idx, m_tbl[exp_idx % DEPTH], 4'(exp_idx)); else n_pass++;
                exp_idx++;
            end
            tick;
            if (held) begin
                n_total++; if (out_valid !== 1'b1 || out_idx !== h_idx || out_vec !== h_vec)
                    $display("FAIL bp_hold c%0d: got v%b %h@%h want v1 %h@%h", c, out_valid, out_vec, out_idx, h_vec, h_idx); else n_pass++;
            end
            if (c == 10) begin
                n_total++; if (cfg_err !== 1'b1) $display("FAIL bp_cfg_err: got %b want 1", cfg_err); else n_pass++;
            end
            if (c == 11) begin
                n_total++; if (cfg_err !== 1'b0) $display("FAIL bp_cfg_err_len: got %b want 0", cfg_err); else n_pass++;
            end
            if (sweep_done) done_cnt++;
        end
        cfg_we = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
        n_total++; if (exp_idx !== DEPTH) $display("FAIL bp_count: got %0d want %0d", exp_idx, DEPTH); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid_sweep;
        logic found;
        int   exp_idx, done_cnt;
        out_ready = 1'b1; sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (out_valid && out_idx == 4'h9) found = 1'b1;
            else tick;
        end
        n_total++; if (found !== 1'b1) $display("FAIL rst_reach_idx9: got %b want 1", found); else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        #1;
        n_total++; if ({out_valid, out_vec, out_idx, cfg_err, sweep_busy, sweep_done} !== '0)
            $display("FAIL rst_async: got v%b %h@%h e%b b%b d%b want all 0", out_valid, out_vec, out_idx, cfg_err, sweep_busy, sweep_done); else n_pass++;
        tick;
        rst = 1'b0;
        tick;
        n_total++; if (sweep_done !== 1'b0 || sweep_busy !== 1'b0)
            $display("FAIL rst_no_done: got busy %b done %b want 0 0", sweep_busy, sweep_done); else n_pass++;
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        exp_idx = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_ready) begin
                n_total++; if (out_idx !== 4'(exp_idx) || out_vec !== m_tbl[exp_idx % DEPTH])
                    $display("FAIL rst_resweep: got %h@%h want %h@%h", out_vec, out_idx, m_tbl[exp_idx % DEPTH], 4'(exp_idx)); else n_pass++;
                exp_idx++;
            end
            tick;
            if (sweep_done) done_cnt++;
        end
        n_total++; if (exp_idx !== DEPTH || done_cnt !== 1)
            $display("FAIL rst_resweep_end: got %0d items %0d done want %0d 1", exp_idx, done_cnt, DEPTH); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_first_eval;
        test_write_eval;
        test_read_before_write;
        test_start_blocked;
        test_random_eval;
        test_sweep;
        test_sweep_backpressure;
        test_reset_mid_sweep;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/breadboard_lut_seq.md
Name: breadboard_lut_seq

Overview:
- Programmable, registered successor to the fixed 4-in/10-out breadboard truth-table block.
- Holds a loadable truth table of 2^N_IN words, each N_OUT bits wide.
- Evaluates input vectors through a valid/ready pipeline with 1-cycle latency.
- A hardware sweep mode walks every minterm in ascending order, replacing the bench's for-loop for table dumps.

Parameters:
- N_IN, 4, number of function inputs (w = MSB ... z = LSB at N_IN=4); legal range 1..8.
- N_OUT, 10, number of output functions (f0 = bit 0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  N_IN  minterm index to write.
- cfg_data  in  N_OUT  output word for cfg_addr.
- cfg_err  out  1  one-cycle pulse: write rejected.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept in_vec.
- in_vec  in  N_IN  minterm to evaluate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_vec  out  N_OUT  table[idx].
- out_idx  out  N_IN  minterm that produced out_vec.
- sweep_start  in  1  start full-table sweep (level sampled).
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after last sweep result accepted.

Behaviour:
- Reset (async assert, sync deassert externally):
  - all table words = 0; state = IDLE.
  - out_valid = 0, out_vec = 0, out_idx = 0.
  - cfg_err = 0, sweep_busy = 0, sweep_done = 0.
  - Reset mid-sweep or mid-handshake aborts without any done pulse.
- FSM states: IDLE, SWEEP.
- Output register (one-deep):
  - load_ok = ~out_valid | out_ready.
  - Register loads on a cycle when load_ok and a source fires.
  - When out_valid & out_ready and nothing loads, out_valid clears next edge.
  - out_vec/out_idx hold stable while out_valid & ~out_ready.
- IDLE:
  - in_ready = load_ok.
  - Accept on in_valid & in_ready: next edge out_vec = table[in_vec], out_idx = in_vec, out_valid = 1.
  - Latency 1 cycle; throughput 1/cycle with out_ready held high.
- Table write:
  - Accepted only in IDLE with out_valid = 0; otherwise ignored and cfg_err pulses next cycle.
  - Write and evaluate of the same address in the same cycle: evaluation returns the OLD word (read-before-write).
- sweep_start:
  - Honoured only in IDLE with out_valid = 0 and in_valid = 0; otherwise ignored, no error.
  - On start: state = SWEEP, sweep_busy = 1 next edge, counter = 0.
- SWEEP:
  - in_ready = 0.
  - Each cycle load_ok holds and counter < 2^N_IN: load table[counter], out_idx = counter, counter++.
  - Counter is N_IN+1 bits so it never wraps.
  - When the final index (2^N_IN - 1) is accepted (out_valid & out_ready):
    - sweep_done = 1 for exactly one cycle;
    - sweep_busy = 0 and state = IDLE on the same edge.
  - cfg_we during SWEEP -> rejected, cfg_err pulse.
  - sweep_start during SWEEP is ignored.
- Back-pressure: out_ready low stalls both eval and sweep indefinitely; no result is dropped or duplicated.

Optional Feature:
- Macro BBL_PARITY_EN.
- Defined:
  - adds output port out_par (1 bit) = ^out_vec, registered alongside out_vec with the same valid/hold rules; reset 0;
  - cfg_data words whose parity disagrees with cfg_data[N_OUT-1] are still written.
- Undefined: port absent, no parity logic.

Decomposition:
- Package bbl_pkg holds:
  - state encoding (IDLE = 0, SWEEP = 1);
  - localparam DEPTH = 1 << N_IN;
  - counter-width helper.
- Natural sub-module bbl_table:
  - DEPTH x N_OUT register array with reset clear;
  - one synchronous write port, one combinational read port.
- The FSM, handshake and output register stay in breadboard_lut_seq.

Test Plan:
- Reset then in_vec = 4'h5, in_valid = 1, out_ready = 1 -> next cycle out_valid = 1, out_vec = 10'h000, out_idx = 5.
- Write table[3] = 10'h2A5, then evaluate 3 -> out_vec = 10'h2A5 one cycle after accept.
- Write 10'h155 to addr 7 while evaluating addr 7 in the same cycle -> out_vec = old word 10'h000; next eval of 7 -> 10'h155.
- Load table[i] = i*3 for all i, sweep_start with out_ready = 1:
  - out_idx 0..15 on 16 consecutive cycles with out_vec = i*3;
  - sweep_done pulses once, in the cycle after index 15 is accepted.
- Sweep with out_ready toggling 1,0,0,1,...:
  - no index skipped or repeated;
  - cfg_we issued mid-sweep -> cfg_err = 1 for one cycle, table unchanged.
- Assert rst during sweep at index 9:
  - all outputs 0 immediately, table cleared, no sweep_done;
  - new sweep restarts at index 0.
